// File: rtl/cpu6502_pkg.sv
// Shared encodings for the 6502 control sequencer: states, ALU codes, bus/select codes
// and the decoded-instruction record produced by opcode_decoder.
package cpu6502_pkg;

  typedef enum logic [3:0] {
    ST_RST, ST_FETCH, ST_IMM, ST_ZP, ST_ABS_LO, ST_ABS_HI,
    ST_MEM_RD, ST_MEM_WR, ST_IMPL, ST_HALT
  } state_e;

  localparam logic [2:0] ALU_ORA  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_EOR  = 3'b010;
  localparam logic [2:0] ALU_ADC  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_CMP  = 3'b110;
  localparam logic [2:0] ALU_SBC  = 3'b111;

  localparam logic [1:0] ASEL_A   = 2'b00;
  localparam logic [1:0] ASEL_X   = 2'b01;
  localparam logic [1:0] ASEL_Y   = 2'b10;
  localparam logic [1:0] ASEL_BUS = 2'b11;

  localparam logic [1:0] ADDR_PC  = 2'b00;
  localparam logic [1:0] ADDR_EA  = 2'b01;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [7:0] OP_NOP = 8'hEA;

  typedef enum logic [1:0] {MODE_IMPL, MODE_IMM, MODE_ZP, MODE_ABS} mode_e;
  typedef enum logic [1:0] {REG_NONE, REG_A, REG_X, REG_Y} reg_e;

  typedef struct packed {
    mode_e      mode;
    logic [2:0] alu_op;
    reg_e       target;
    reg_e       source;
    logic       is_store;
    logic       is_cmp;
    logic       legal;
  } dec_t;

  function automatic logic [1:0] reg_to_asel(reg_e r);
    case (r)
      REG_X:   return ASEL_X;
      REG_Y:   return ASEL_Y;
      default: return ASEL_A;
    endcase
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: addressing mode, ALU op and register routing.
// Illegal opcodes come out as an inert implied-mode record with legal=0.
module opcode_decoder
  import cpu6502_pkg::*;
#(
  parameter bit ENABLE_ABS = 1'b1
) (
  input  logic [7:0] ir,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.mode   = MODE_IMPL;
    dec.alu_op = ALU_PASS;
    dec.target = REG_NONE;
    dec.source = REG_NONE;
    if (ir == OP_NOP) begin
      dec.legal = 1'b1;
    end else if (ir[1:0] == 2'b01) begin
      case (ir[4:2])
        3'b010:  begin dec.mode = MODE_IMM; dec.legal = 1'b1; end
        3'b001:  begin dec.mode = MODE_ZP;  dec.legal = 1'b1; end
        3'b011:  begin dec.mode = MODE_ABS; dec.legal = 1'b1; end
        default: dec.legal = 1'b0;
      endcase
      // aaa doubles as the ALU code except for STA/LDA, which pass the bus through
      case (ir[7:5])
        3'b100: begin
          dec.is_store = 1'b1;
          dec.source   = REG_A;
          if (dec.mode == MODE_IMM) dec.legal = 1'b0;
        end
        3'b101: dec.target = REG_A;
        3'b110: begin dec.is_cmp = 1'b1; dec.alu_op = ALU_CMP; end
        default: begin dec.alu_op = ir[7:5]; dec.target = REG_A; end
      endcase
    end else begin
      case (ir)
        8'hA2: begin dec.legal = 1'b1; dec.mode = MODE_IMM; dec.target = REG_X; end
        8'hA6: begin dec.legal = 1'b1; dec.mode = MODE_ZP;  dec.target = REG_X; end
        8'hAE: begin dec.legal = 1'b1; dec.mode = MODE_ABS; dec.target = REG_X; end
        8'hA0: begin dec.legal = 1'b1; dec.mode = MODE_IMM; dec.target = REG_Y; end
        8'hA4: begin dec.legal = 1'b1; dec.mode = MODE_ZP;  dec.target = REG_Y; end
        8'hAC: begin dec.legal = 1'b1; dec.mode = MODE_ABS; dec.target = REG_Y; end
        8'h86: begin dec.legal = 1'b1; dec.mode = MODE_ZP;  dec.is_store = 1'b1; dec.source = REG_X; end
        8'h8E: begin dec.legal = 1'b1; dec.mode = MODE_ABS; dec.is_store = 1'b1; dec.source = REG_X; end
        8'h84: begin dec.legal = 1'b1; dec.mode = MODE_ZP;  dec.is_store = 1'b1; dec.source = REG_Y; end
        8'h8C: begin dec.legal = 1'b1; dec.mode = MODE_ABS; dec.is_store = 1'b1; dec.source = REG_Y; end
        default: dec.legal = 1'b0;
      endcase
    end
    if (!ENABLE_ABS && dec.mode == MODE_ABS) dec.legal = 1'b0;
    if (!dec.legal) begin
      dec.mode     = MODE_IMPL;
      dec.alu_op   = ALU_PASS;
      dec.target   = REG_NONE;
      dec.source   = REG_NONE;
      dec.is_store = 1'b0;
      dec.is_cmp   = 1'b0;
    end
  end

endmodule

// File: rtl/sequencing_control_unit.sv
// Multi-cycle 6502 control sequencer. Moore outputs from state + latched IR; every
// load/increment strobe is qualified by mem_ready so wait states never double-fire.
module sequencing_control_unit
  import cpu6502_pkg::*;
#(
  parameter int ALU_OP_W        = 3,
  parameter bit ENABLE_ABS      = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_ready,
  input  logic [7:0]          opcode,
  output logic                instruction_load,
  output logic                increment_pc,
  output logic                a_load,
  output logic                x_load,
  output logic                y_load,
  output logic                flags_load,
  output logic                addr_lo_load,
  output logic                addr_hi_load,
  output logic                addr_hi_clear,
  output logic                read_write,
  output logic [1:0]          address_select,
  output logic [1:0]          alu_select,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                sync,
  output logic                halted
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  dec_t       fdec, idec;

  // fdec steers the FETCH transition from the live bus; idec drives execution from IR
  opcode_decoder #(.ENABLE_ABS(ENABLE_ABS)) u_dec_fetch (.ir(opcode), .dec(fdec));
  opcode_decoder #(.ENABLE_ABS(ENABLE_ABS)) u_dec_ir    (.ir(ir_q),   .dec(idec));

  logic unused_dec;
  assign unused_dec = ^{fdec, idec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      ir_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) begin
        ir_d = opcode;
        if (!fdec.legal) state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_IMPL;
        else begin
          case (fdec.mode)
            MODE_IMM: state_d = ST_IMM;
            MODE_ZP:  state_d = ST_ZP;
            MODE_ABS: state_d = ST_ABS_LO;
            default:  state_d = ST_IMPL;
          endcase
        end
      end
      ST_ZP, ST_ABS_HI: if (mem_ready) state_d = idec.is_store ? ST_MEM_WR : ST_MEM_RD;
      ST_ABS_LO:        if (mem_ready) state_d = ST_ABS_HI;
      ST_IMM, ST_MEM_RD, ST_MEM_WR, ST_IMPL:
                        if (mem_ready) state_d = ST_FETCH;
      ST_HALT:          state_d = ST_HALT;
      default:          state_d = ST_RST;
    endcase
  end

  logic       ld_ir, inc, ld_a, ld_x, ld_y, ld_f, ld_lo, ld_hi, clr_hi, exec;
  logic [2:0] op3;

  always_comb begin
    ld_ir = 1'b0; inc = 1'b0; ld_lo = 1'b0; ld_hi = 1'b0; clr_hi = 1'b0; exec = 1'b0;
    read_write     = RW_READ;
    address_select = ADDR_PC;
    alu_select     = ASEL_A;
    op3            = ALU_PASS;
    sync           = 1'b0;
    halted         = 1'b0;
    case (state_q)
      ST_FETCH:  begin sync = 1'b1; ld_ir = 1'b1; inc = 1'b1; end
      ST_IMM:    begin inc = 1'b1; exec = 1'b1; end
      ST_ZP:     begin ld_lo = 1'b1; clr_hi = 1'b1; inc = 1'b1; end
      ST_ABS_LO: begin ld_lo = 1'b1; inc = 1'b1; end
      ST_ABS_HI: begin ld_hi = 1'b1; inc = 1'b1; end
      ST_MEM_RD: begin address_select = ADDR_EA; exec = 1'b1; end
      ST_MEM_WR: begin
        address_select = ADDR_EA;
        read_write     = RW_WRITE;
        alu_select     = reg_to_asel(idec.source);
      end
      ST_HALT:   halted = 1'b1;
      default:   ;
    endcase
    if (exec) begin
      alu_select = ASEL_BUS;
      op3        = idec.alu_op;
    end
  end

  assign ld_f = exec;
  assign ld_a = exec && idec.target == REG_A && !idec.is_cmp;
  assign ld_x = exec && idec.target == REG_X;
  assign ld_y = exec && idec.target == REG_Y;

  assign instruction_load = ld_ir  & mem_ready;
  assign increment_pc     = inc    & mem_ready;
  assign a_load           = ld_a   & mem_ready;
  assign x_load           = ld_x   & mem_ready;
  assign y_load           = ld_y   & mem_ready;
  assign flags_load       = ld_f   & mem_ready;
  assign addr_lo_load     = ld_lo  & mem_ready;
  assign addr_hi_load     = ld_hi  & mem_ready;
  assign addr_hi_clear    = clr_hi & mem_ready;
  assign alu_opcode       = ALU_OP_W'(op3);

endmodule

// File: tb/tb_sequencing_control_unit.sv
// Bench for sequencing_control_unit: default build (abs on, halt on illegal) on channel 0,
// abs-off / illegal-as-NOP build on channel 1, checked against per-instruction cycle scripts.
module tb_sequencing_control_unit;

  typedef struct packed {
    logic ilo, ipc, al, xl, yl, fl, alo, ahi, ahc, rw;
    logic [1:0] as, als;
    logic [2:0] op;
    logic sync, halted;
  } out_t;

  typedef struct {
    logic       rdy;
    logic [7:0] opc;
    out_t       exp;
  } vec_t;

  localparam logic [8:0] ILO = 9'h100, IPC = 9'h080, AL = 9'h040, XL = 9'h020, YL = 9'h010;
  localparam logic [8:0] FL  = 9'h008, ALO = 9'h004, AHI = 9'h002, AHC = 9'h001;

  logic clk = 1'b0;
  logic rst_n, rdy;
  logic [1:0][7:0] opc;
  logic [1:0] ilo, ipc, al, xl, yl, fl, alo, ahi, ahc, rw, syn, hlt;
  logic [1:0][1:0] asel, alsel;
  logic [1:0][2:0] aop;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sequencing_control_unit #(.ALU_OP_W(3), .ENABLE_ABS(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_ready(rdy), .opcode(opc[0]),
    .instruction_load(ilo[0]), .increment_pc(ipc[0]), .a_load(al[0]), .x_load(xl[0]),
    .y_load(yl[0]), .flags_load(fl[0]), .addr_lo_load(alo[0]), .addr_hi_load(ahi[0]),
    .addr_hi_clear(ahc[0]), .read_write(rw[0]), .address_select(asel[0]),
    .alu_select(alsel[0]), .alu_opcode(aop[0]), .sync(syn[0]), .halted(hlt[0]));

  sequencing_control_unit #(.ALU_OP_W(3), .ENABLE_ABS(1'b0), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_ready(rdy), .opcode(opc[1]),
    .instruction_load(ilo[1]), .increment_pc(ipc[1]), .a_load(al[1]), .x_load(xl[1]),
    .y_load(yl[1]), .flags_load(fl[1]), .addr_lo_load(alo[1]), .addr_hi_load(ahi[1]),
    .addr_hi_clear(ahc[1]), .read_write(rw[1]), .address_select(asel[1]),
    .alu_select(alsel[1]), .alu_opcode(aop[1]), .sync(syn[1]), .halted(hlt[1]));

  function automatic out_t mk(logic [8:0] s, logic w, logic [1:0] a, logic [1:0] l,
                              logic [2:0] o, logic sy, logic h);
    out_t r;
    r = {s, w, a, l, o, sy, h};
    return r;
  endfunction

  function automatic out_t act(int ch);
    out_t r;
    r = {ilo[ch], ipc[ch], al[ch], xl[ch], yl[ch], fl[ch], alo[ch], ahi[ch], ahc[ch],
         rw[ch], asel[ch], alsel[ch], aop[ch], syn[ch], hlt[ch]};
    return r;
  endfunction

  function automatic out_t stall(out_t e);
    out_t m;
    m = e;
    m[18:10] = 9'h000;
    return m;
  endfunction

  task automatic check(input string nm, input int ch, input out_t e);
    out_t a;
    a = act(ch);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s ch%0d t=%0t actual=%05h required=%05h", nm, ch, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-set reference: kind 0 illegal, 1 NOP, 2 read/ALU, 3 store;
  // mode 0 imm, 1 zp, 2 abs.
  function automatic void ref_decode(input logic [7:0] o, input bit en_abs,
                                     output int kind, output int mode,
                                     output logic [8:0] ld, output logic [1:0] src,
                                     output logic [2:0] aluop);
    logic [2:0] tab [8];
    int aaa;
    tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd7};
    kind = 0; mode = -1; ld = 9'h0; src = 2'd0; aluop = 3'd4;
    if (o == 8'hEA) kind = 1;
    else if (o[1:0] == 2'b01) begin
      case (o[4:2])
        3'd2: mode = 0;
        3'd1: mode = 1;
        3'd3: mode = 2;
        default: mode = -1;
      endcase
      aaa = int'(o[7:5]);
      if (mode >= 0) begin
        if (aaa == 4) kind = (mode == 0) ? 0 : 3;
        else begin
          kind = 2;
          aluop = tab[aaa];
          ld = (aaa == 6) ? 9'h0 : AL;
        end
      end
    end else begin
      case (o)
        8'hA2: begin kind = 2; mode = 0; ld = XL; end
        8'hA6: begin kind = 2; mode = 1; ld = XL; end
        8'hAE: begin kind = 2; mode = 2; ld = XL; end
        8'hA0: begin kind = 2; mode = 0; ld = YL; end
        8'hA4: begin kind = 2; mode = 1; ld = YL; end
        8'hAC: begin kind = 2; mode = 2; ld = YL; end
        8'h86: begin kind = 3; mode = 1; src = 2'd1; end
        8'h8E: begin kind = 3; mode = 2; src = 2'd1; end
        8'h84: begin kind = 3; mode = 1; src = 2'd2; end
        8'h8C: begin kind = 3; mode = 2; src = 2'd2; end
        default: kind = 0;
      endcase
    end
    if (kind >= 2 && mode == 2 && !en_abs) kind = 0;
  endfunction

  out_t       seq [2][4];
  int         len [2];
  int         idx [2];
  logic [7:0] cur [2];
  logic [7:0] legal_ops [$];

  // Expected bus-cycle script for one instruction (no halting opcodes are fed here).
  function automatic void build(input int ch, input logic [7:0] o);
    int kind, mode;
    logic [8:0] ld;
    logic [1:0] src;
    logic [2:0] aluop;
    out_t mem;
    ref_decode(o, ch == 0, kind, mode, ld, src, aluop);
    cur[ch] = o;
    seq[ch][0] = mk(ILO | IPC, 0, 2'd0, 2'd0, 3'd4, 1, 0);
    mem = (kind == 3) ? mk(9'h0, 1, 2'd1, src, 3'd4, 0, 0)
                      : mk(ld | FL, 0, 2'd1, 2'd3, aluop, 0, 0);
    if (kind <= 1) begin
      seq[ch][1] = mk(9'h0, 0, 2'd0, 2'd0, 3'd4, 0, 0);
      len[ch] = 2;
    end else if (mode == 0) begin
      seq[ch][1] = mk(IPC | ld | FL, 0, 2'd0, 2'd3, aluop, 0, 0);
      len[ch] = 2;
    end else if (mode == 1) begin
      seq[ch][1] = mk(ALO | AHC | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0);
      seq[ch][2] = mem;
      len[ch] = 3;
    end else begin
      seq[ch][1] = mk(ALO | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0);
      seq[ch][2] = mk(AHI | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0);
      seq[ch][3] = mem;
      len[ch] = 4;
    end
  endfunction

  initial begin
    vec_t tbl [15];
    out_t v_fetch, v_idle, v_halt;
    int kind, mode;
    logic [8:0] ld;
    logic [1:0] src;
    logic [2:0] aluop;

    v_fetch = mk(ILO | IPC, 0, 2'd0, 2'd0, 3'd4, 1, 0);
    v_idle  = mk(9'h0, 0, 2'd0, 2'd0, 3'd4, 0, 0);
    v_halt  = mk(9'h0, 0, 2'd0, 2'd0, 3'd4, 0, 1);

    // LDA #$42 ; ADC $10 with two MEM_RD waits ; STA $1234 ; stalled FETCH of NOP ; NOP
    tbl[0]  = '{1'b1, 8'hA9, v_fetch};
    tbl[1]  = '{1'b1, 8'h42, mk(IPC | AL | FL, 0, 2'd0, 2'd3, 3'd4, 0, 0)};
    tbl[2]  = '{1'b1, 8'h65, v_fetch};
    tbl[3]  = '{1'b1, 8'h10, mk(ALO | AHC | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0)};
    tbl[4]  = '{1'b0, 8'h00, mk(9'h0, 0, 2'd1, 2'd3, 3'd3, 0, 0)};
    tbl[5]  = '{1'b0, 8'h00, mk(9'h0, 0, 2'd1, 2'd3, 3'd3, 0, 0)};
    tbl[6]  = '{1'b1, 8'h00, mk(AL | FL, 0, 2'd1, 2'd3, 3'd3, 0, 0)};
    tbl[7]  = '{1'b1, 8'h8D, v_fetch};
    tbl[8]  = '{1'b1, 8'h34, mk(ALO | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0)};
    tbl[9]  = '{1'b1, 8'h12, mk(AHI | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0)};
    tbl[10] = '{1'b1, 8'h00, mk(9'h0, 1, 2'd1, 2'd0, 3'd4, 0, 0)};
    tbl[11] = '{1'b0, 8'hEA, mk(9'h0, 0, 2'd0, 2'd0, 3'd4, 1, 0)};
    tbl[12] = '{1'b1, 8'hEA, v_fetch};
    tbl[13] = '{1'b1, 8'h00, v_idle};
    tbl[14] = '{1'b1, 8'hA9, v_fetch};

    for (int i = 0; i < 256; i++) begin
      ref_decode(8'(i), 1'b1, kind, mode, ld, src, aluop);
      if (kind != 0) legal_ops.push_back(8'(i));
    end

    rst_n = 1'b0; rdy = 1'b1; opc[0] = 8'hEA; opc[1] = 8'hEA;
    tick(); #3;
    check("reset_hold", 0, v_idle);
    check("reset_hold", 1, v_idle);
    tick(); rst_n = 1'b1; #3;
    check("reset_release", 0, v_idle);
    tick();

    for (int i = 0; i < 15; i++) begin
      rdy = tbl[i].rdy; opc[0] = tbl[i].opc;
      #3;
      check($sformatf("table%0d", i), 0, tbl[i].exp);
      tick();
    end

    // reset lands in IMM of LDA: strobes must drop without a clock
    rst_n = 1'b0; #1;
    check("async_reset_imm", 0, v_idle);
    tick(); rst_n = 1'b1; #3;
    check("rst_cycle", 0, v_idle);
    tick();

    // ch0 illegal 0x02 -> HALT ; ch1 LDA abs with abs disabled -> IMPL
    opc[0] = 8'h02; opc[1] = 8'hAD; rdy = 1'b1; #3;
    check("illegal_fetch", 0, v_fetch);
    check("absoff_fetch", 1, v_fetch);
    tick(); opc[0] = 8'($urandom); opc[1] = 8'hEA; #3;
    check("halt_entry", 0, v_halt);
    check("absoff_impl", 1, v_idle);
    tick(); #3;
    check("absoff_refetch", 1, v_fetch);
    for (int i = 0; i < 22; i++) begin
      rdy = 1'($urandom); opc[0] = 8'($urandom);
      #3;
      check("halt_stay", 0, v_halt);
      tick();
    end
    rdy = 1'b1; rst_n = 1'b0; #1;
    check("halt_reset", 0, v_idle);
    tick(); rst_n = 1'b1; #3;
    check("halt_rst_cycle", 0, v_idle);
    tick(); opc[0] = 8'hAE; #3;
    check("ldx_fetch", 0, v_fetch);

    // reset during ABS_HI of LDX $2000
    tick(); opc[0] = 8'h00; #3;
    check("ldx_abs_lo", 0, mk(ALO | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0));
    tick(); opc[0] = 8'h20; #2;
    check("ldx_abs_hi", 0, mk(AHI | IPC, 0, 2'd0, 2'd0, 3'd4, 0, 0));
    #1 rst_n = 1'b0; #1;
    check("ldx_async_abort", 0, v_idle);
    tick(); rst_n = 1'b1; #3;
    check("ldx_rst_cycle", 0, v_idle);
    tick();

    // randomized instruction streams with random wait states
    idx[0] = 0; idx[1] = 0; len[0] = 0; len[1] = 0;
    for (int c = 0; c < 900; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < 2; ch++) begin
        if (idx[ch] == len[ch]) begin
          if (ch == 0) build(0, legal_ops[$urandom_range(0, legal_ops.size() - 1)]);
          else         build(1, 8'($urandom));
          idx[ch] = 0;
        end
        opc[ch] = (idx[ch] == 0) ? cur[ch] : 8'($urandom);
      end
      #3;
      for (int ch = 0; ch < 2; ch++)
        check($sformatf("rand_op%02h_c%0d", cur[ch], idx[ch]), ch,
              rdy ? seq[ch][idx[ch]] : stall(seq[ch][idx[ch]]));
      tick();
      if (rdy) begin idx[0]++; idx[1]++; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
